// File: rtl/rob_commit.sv
// Reorder buffer: accepts renamed ops, tracks completion, retires up to cwd per cycle in order.
// On a head exception it drains rename, walks youngest-to-oldest emitting rollbacks, then redirects.
package rob_commit_pkg;
  typedef struct packed {
    logic [15:0]     opid;
    logic [4:0]      rda;
    logic [1:0][5:0] prda;  // [0] old mapping, [1] new mapping
  } ren_bundle_t;

  typedef struct packed {
    logic [15:0]     opid;
    logic [4:0]      lrda;
    logic [1:0][5:0] prda;
  } com_bundle_t;

  typedef struct packed {
    logic [15:0] opid;
    logic [7:0]  brid;
    logic        rollback;
  } red_bundle_t;
endpackage

module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int rwd   = 2,
  parameter int cwd   = 2,
  parameter int wbw   = 2,
  parameter int robsz = 16,
  localparam int IW  = $clog2(robsz),
  localparam int CW  = IW + 1,
  localparam int RW  = $bits(ren_bundle_t),
  localparam int CBW = $bits(com_bundle_t),
  localparam int RBW = $bits(red_bundle_t)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [rwd*RW-1:0]  ren_bundle,
  output logic [rwd-1:0]     rename,
  input  logic [wbw-1:0]     wb_valid,
  input  logic [wbw*IW-1:0]  wb_idx,
  input  logic [wbw-1:0]     wb_exc,
  input  logic               br_valid,
  input  logic [IW-1:0]      br_idx,
  output logic [rwd*IW-1:0]  rob_idx,
  output logic [cwd*CBW-1:0] com_bundle,
  output logic [RBW-1:0]     red_bundle
);

  typedef enum logic [1:0] {RUN, DRAIN, WALK, REDIR} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [15:0]            exc_opid_q, exc_opid_d;
  logic [robsz-1:0]       vld_q, vld_d, done_q, done_d, exc_q, exc_d;
  ren_bundle_t [robsz-1:0] ent_q, ent_d;

  ren_bundle_t [rwd-1:0]   ren_s;
  com_bundle_t [cwd-1:0]   com_s;
  red_bundle_t             red_s;
  logic [rwd-1:0][IW-1:0]  rob_idx_s;
  logic [wbw-1:0][IW-1:0]  wb_idx_s;

  logic [IW-1:0] idx, off, br_next, killed;
  logic [CW-1:0] n_acc, n_com, n_walk, free;
  logic          in_order, take, head_exc;

  assign ren_s      = ren_bundle;
  assign wb_idx_s   = wb_idx;
  assign com_bundle = com_s;
  assign red_bundle = red_s;
  assign rob_idx    = rob_idx_s;

  function automatic com_bundle_t to_com(input ren_bundle_t e);
    com_bundle_t c;
    c.opid = e.opid | 16'h8000;
    c.lrda = e.rda;
    c.prda = e.prda;
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < rwd; i++) rob_idx_s[i] = tail_q + IW'(i);
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    exc_opid_d = exc_opid_q;
    vld_d      = vld_q;
    done_d     = done_q;
    exc_d      = exc_q;
    ent_d      = ent_q;
    rename     = '0;
    com_s      = '0;
    red_s      = '0;
    idx        = '0;
    off        = '0;
    n_acc      = '0;
    n_com      = '0;
    n_walk     = '0;
    in_order   = 1'b1;
    take       = 1'b1;
    br_next    = br_idx + IW'(1);
    killed     = tail_q - br_next;
    free       = CW'(robsz) - count_q;
    head_exc   = vld_q[head_q] & done_q[head_q] & exc_q[head_q];

    case (state_q)
      RUN: begin
        for (int k = 0; k < wbw; k++) begin
          if (wb_valid[k] && vld_q[wb_idx_s[k]]) begin
            done_d[wb_idx_s[k]] = 1'b1;
            exc_d[wb_idx_s[k]]  = exc_d[wb_idx_s[k]] | wb_exc[k];
          end
        end
        // done_q is the registered flag, so same-cycle writebacks wait a cycle to retire
        for (int i = 0; i < cwd; i++) begin
          idx      = head_q + IW'(i);
          in_order = in_order & vld_q[idx] & done_q[idx] & ~exc_q[idx];
          if (in_order) begin
            com_s[i]   = to_com(ent_q[idx]);
            vld_d[idx] = 1'b0;
            n_com      = n_com + CW'(1);
          end
        end
        head_d = head_q + IW'(n_com);

        if (head_exc) begin
          exc_opid_d     = ent_q[head_q].opid;
          red_s.rollback = 1'b1;
          state_d        = DRAIN;
        end else if (br_valid) begin
          for (int j = 0; j < robsz; j++) begin
            off = IW'(j) - br_next;
            if (off < killed) vld_d[j] = 1'b0;
          end
          tail_d  = br_next;
          count_d = count_q - n_com - CW'(killed);
        end else begin
          for (int i = 0; i < rwd; i++) begin
            idx  = tail_q + IW'(i);
            take = take & ren_s[i].opid[15] & (CW'(i) < free);
            if (take) begin
              rename[i]   = 1'b1;
              ent_d[idx]  = ren_s[i];
              vld_d[idx]  = 1'b1;
              done_d[idx] = 1'b0;
              exc_d[idx]  = 1'b0;
              n_acc       = n_acc + CW'(1);
            end
          end
          tail_d  = tail_q + IW'(n_acc);
          count_d = count_q + n_acc - n_com;
        end
      end
      DRAIN: begin
        red_s.rollback = 1'b1;
        if (!ren_s[0].opid[15]) state_d = WALK;
      end
      WALK: begin
        red_s.rollback = 1'b1;
        for (int i = 0; i < cwd; i++) begin
          if (CW'(i) < count_q) begin
            idx        = tail_q - IW'(i + 1);
            com_s[i]   = to_com(ent_q[idx]);
            vld_d[idx] = 1'b0;
            n_walk     = n_walk + CW'(1);
          end
        end
        tail_d  = tail_q - IW'(n_walk);
        count_d = count_q - n_walk;
        if (count_d == '0) state_d = REDIR;
      end
      REDIR: begin
        red_s.opid = exc_opid_q | 16'h8000;
        head_d     = tail_q;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      exc_opid_q <= '0;
      vld_q      <= '0;
      done_q     <= '0;
      exc_q      <= '0;
      ent_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      exc_opid_q <= exc_opid_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
      ent_q      <= ent_d;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: a fill table, directed commit/exception/branch/wrap/reset
// sequences, then a random run checked against a queue model of the buffer.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  ren_bundle_t [1:0] ren_v;
  logic [1:0]        rename;
  logic [1:0]        wb_valid, wb_exc;
  logic [1:0][3:0]   wb_idx_v;
  logic              br_valid;
  logic [3:0]        br_idx;
  logic [1:0][3:0]   rob_idx_v;
  com_bundle_t [1:0] com_v;
  red_bundle_t       red_v;

  int n_chk  = 0;
  int n_fail = 0;

  rob_commit dut (
    .clk(clk), .rst(rst), .ren_bundle(ren_v), .rename(rename),
    .wb_valid(wb_valid), .wb_idx(wb_idx_v), .wb_exc(wb_exc),
    .br_valid(br_valid), .br_idx(br_idx), .rob_idx(rob_idx_v),
    .com_bundle(com_v), .red_bundle(red_v)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ren_bundle_t mk(input int s);
    ren_bundle_t r;
    r.opid    = 16'h8000 | 16'(s);
    r.rda     = 5'(s);
    r.prda[0] = 6'(s);
    r.prda[1] = 6'(s) ^ 6'h2a;
    return r;
  endfunction

  function automatic com_bundle_t cxr(input ren_bundle_t r);
    com_bundle_t c;
    c.opid = r.opid | 16'h8000;
    c.lrda = r.rda;
    c.prda = r.prda;
    return c;
  endfunction

  function automatic com_bundle_t cx(input int s);
    return cxr(mk(s));
  endfunction

  task automatic idle_in();
    ren_v    = '0;
    wb_valid = '0;
    wb_exc   = '0;
    wb_idx_v = '0;
    br_valid = 1'b0;
    br_idx   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic disp(input int s, input bit two);
    ren_v[0] = mk(s);
    ren_v[1] = two ? mk(s + 1) : '0;
  endtask

  task automatic wb2(input int a, input int b);
    wb_valid    = 2'b11;
    wb_idx_v[0] = 4'(a);
    wb_idx_v[1] = 4'(b);
  endtask

  task automatic wb1(input int a, input bit e);
    wb_valid    = 2'b01;
    wb_exc      = {1'b0, e};
    wb_idx_v[0] = 4'(a);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    smp();
    chk("rst_com0_opid", 64'(com_v[0].opid), 64'd0);
    chk("rst_rollback", 64'(red_v.rollback), 64'd0);
    chk("rst_rob_idx1", 64'(rob_idx_v[1]), 64'd1);
    chk("rst_count", 64'(dut.count_q), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0] vmask;
    logic [1:0] exp_ren;
    logic [3:0] exp_ri0;
    logic [4:0] exp_cnt;
  } vec_t;

  typedef struct {
    ren_bundle_t e;
    bit          done;
  } ment_t;

  vec_t  vt[10];
  ment_t mq[$];

  initial begin
    int          seq, mhead, ncom, off, sz;
    logic [1:0]  vm, exp_ren;
    com_bundle_t ec [2];
    ren_bundle_t r;
    ment_t       m;

    vt[0] = '{2'b10, 2'b00, 4'd0, 5'd0};
    for (int k = 1; k <= 8; k++) vt[k] = '{2'b11, 2'b11, 4'(2 * (k - 1)), 5'(2 * (k - 1))};
    vt[9] = '{2'b11, 2'b00, 4'd0, 5'd16};

    idle_in();
    do_reset();

    // fill to full, including a non-prefix valid pattern and rob_idx wrap
    seq = 16'h10;
    for (int i = 0; i < 10; i++) begin
      ren_v[0] = vt[i].vmask[0] ? mk(seq) : '0;
      ren_v[1] = vt[i].vmask[1] ? mk(seq + 1) : '0;
      seq += 2;
      smp();
      chk($sformatf("fill_rename_%0d", i), 64'(rename), 64'(vt[i].exp_ren));
      chk($sformatf("fill_rob_idx0_%0d", i), 64'(rob_idx_v[0]), 64'(vt[i].exp_ri0));
      chk($sformatf("fill_rob_idx1_%0d", i), 64'(rob_idx_v[1]), 64'(4'(vt[i].exp_ri0 + 4'd1)));
      chk($sformatf("fill_count_%0d", i), 64'(dut.count_q), 64'(vt[i].exp_cnt));
      step();
    end

    // out-of-order writeback, in-order commit
    do_reset();
    disp(16'h20, 1); step();
    disp(16'h22, 1); step();
    wb1(1, 0); smp();
    chk("ooo_no_commit_a", 64'(com_v[0].opid), 64'd0);
    step();
    wb1(0, 0); smp();
    chk("ooo_no_commit_b", 64'(com_v[0].opid), 64'd0);
    step(); smp();
    chk("ooo_com0", 64'(com_v[0]), 64'(cx(16'h20)));
    chk("ooo_com1", 64'(com_v[1]), 64'(cx(16'h21)));
    step(); smp();
    chk("ooo_count", 64'(dut.count_q), 64'd2);
    chk("ooo_head", 64'(dut.head_q), 64'd2);
    chk("ooo_rest_idle", 64'(com_v[0].opid), 64'd0);

    // exception: drain, walk, redirect
    do_reset();
    disp(16'h100, 1); step();
    disp(16'h102, 1); step();
    disp(16'h104, 0); step();
    wb1(0, 1); smp();
    chk("exc_wb_cycle_rb", 64'(red_v.rollback), 64'd0);
    step();
    ren_v[0] = mk(16'h150); smp();
    chk("exc_detect_rename", 64'(rename), 64'd0);
    chk("exc_detect_rb", 64'(red_v.rollback), 64'd1);
    chk("exc_detect_nocom", 64'(com_v[0].opid), 64'd0);
    step();
    ren_v[0] = mk(16'h151); smp();
    chk("drain1_rename", 64'(rename), 64'd0);
    chk("drain1_rb", 64'(red_v.rollback), 64'd1);
    step(); smp();
    chk("drain2_nocom", 64'(com_v[0].opid), 64'd0);
    step(); smp();
    chk("walk1_com0", 64'(com_v[0]), 64'(cx(16'h104)));
    chk("walk1_com1", 64'(com_v[1]), 64'(cx(16'h103)));
    chk("walk1_rb", 64'(red_v.rollback), 64'd1);
    step(); smp();
    chk("walk2_com0", 64'(com_v[0]), 64'(cx(16'h102)));
    chk("walk2_com1", 64'(com_v[1]), 64'(cx(16'h101)));
    step(); smp();
    chk("walk3_com0", 64'(com_v[0]), 64'(cx(16'h100)));
    chk("walk3_com1_opid", 64'(com_v[1].opid), 64'd0);
    step(); smp();
    chk("redir_opid", 64'(red_v.opid), 64'h8100);
    chk("redir_rb", 64'(red_v.rollback), 64'd0);
    chk("redir_brid", 64'(red_v.brid), 64'd0);
    chk("redir_count", 64'(dut.count_q), 64'd0);
    chk("redir_nocom", 64'(com_v[0].opid), 64'd0);
    step();
    disp(16'h160, 1); smp();
    chk("post_redir_rename", 64'(rename), 64'd3);
    chk("post_redir_rob_idx", 64'(rob_idx_v[0]), 64'd0);
    chk("post_redir_opid", 64'(red_v.opid), 64'd0);
    step();

    // branch mispredict truncates the tail
    do_reset();
    disp(16'h200, 1); step();
    disp(16'h202, 1); step();
    disp(16'h204, 1); step();
    br_valid = 1'b1; br_idx = 4'd2; ren_v[0] = mk(16'h206); smp();
    chk("br_rename_blocked", 64'(rename), 64'd0);
    step();
    disp(16'h210, 0); smp();
    chk("br_count", 64'(dut.count_q), 64'd3);
    chk("br_tail", 64'(dut.tail_q), 64'd3);
    chk("br_rob_idx0", 64'(rob_idx_v[0]), 64'd3);
    chk("br_redispatch", 64'(rename), 64'd1);
    step();
    wb2(0, 1); step();
    wb2(2, 3); smp();
    chk("br_com0_a", 64'(com_v[0]), 64'(cx(16'h200)));
    chk("br_com1_a", 64'(com_v[1]), 64'(cx(16'h201)));
    step(); smp();
    chk("br_com0_b", 64'(com_v[0]), 64'(cx(16'h202)));
    chk("br_com1_b", 64'(com_v[1]), 64'(cx(16'h210)));
    step(); smp();
    chk("br_final_count", 64'(dut.count_q), 64'd0);

    // head wraps from 14 to 0
    do_reset();
    for (int c = 0; c < 8; c++) begin
      disp(16'h300 + 2 * c, 1); step();
    end
    for (int c = 0; c < 7; c++) begin
      wb2(2 * c, 2 * c + 1); step();
    end
    wb2(14, 15); step(); smp();
    chk("wrap_head14", 64'(dut.head_q), 64'd14);
    chk("wrap_com0", 64'(com_v[0]), 64'(cx(16'h30e)));
    chk("wrap_com1", 64'(com_v[1]), 64'(cx(16'h30f)));
    step(); smp();
    chk("wrap_head0", 64'(dut.head_q), 64'd0);
    chk("wrap_count0", 64'(dut.count_q), 64'd0);

    // reset asserted in the middle of a walk
    do_reset();
    disp(16'h400, 1); step();
    disp(16'h402, 1); step();
    wb1(0, 1); step();
    step();
    step(); smp();
    chk("rstwalk_in_walk", 64'(com_v[0]), 64'(cx(16'h403)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    chk("rstwalk_com0", 64'(com_v[0].opid), 64'd0);
    chk("rstwalk_com1", 64'(com_v[1].opid), 64'd0);
    chk("rstwalk_rb", 64'(red_v.rollback), 64'd0);
    chk("rstwalk_count", 64'(dut.count_q), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // random dispatch/writeback against a queue model
    do_reset();
    mq.delete();
    mhead = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      vm = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        r.opid    = 16'h8000 | 16'($urandom_range(0, 32767));
        r.rda     = 5'($urandom_range(0, 31));
        r.prda[0] = 6'($urandom_range(0, 63));
        r.prda[1] = 6'($urandom_range(0, 63));
        ren_v[i]  = vm[i] ? r : '0;
      end
      sz = mq.size();
      for (int k = 0; k < 2; k++) begin
        wb_valid[k] = 1'($urandom_range(0, 1));
        if (sz > 0 && $urandom_range(0, 3) != 0)
          wb_idx_v[k] = 4'((mhead + int'($urandom_range(0, sz - 1))) % 16);
        else
          wb_idx_v[k] = 4'($urandom_range(0, 15));
      end

      ncom = 0;
      ec[0] = '0;
      ec[1] = '0;
      for (int i = 0; i < 2; i++) begin
        if (i < sz && ncom == i && mq[i].done) begin
          ec[i] = cxr(mq[i].e);
          ncom++;
        end
      end
      exp_ren = '0;
      for (int i = 0; i < 2; i++)
        if (ren_v[i].opid[15] && i < 16 - sz && (i == 0 || exp_ren[0])) exp_ren[i] = 1'b1;

      smp();
      chk("rnd_rename", 64'(rename), 64'(exp_ren));
      chk("rnd_com0", 64'(com_v[0]), 64'(ec[0]));
      chk("rnd_com1", 64'(com_v[1]), 64'(ec[1]));
      chk("rnd_rob_idx0", 64'(rob_idx_v[0]), 64'((mhead + sz) % 16));

      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k]) begin
          off = (int'(wb_idx_v[k]) - mhead + 16) % 16;
          if (off < sz) mq[off].done = 1'b1;
        end
      end
      for (int i = 0; i < ncom; i++) void'(mq.pop_front());
      mhead = (mhead + ncom) % 16;
      for (int i = 0; i < 2; i++) begin
        if (exp_ren[i]) begin
          m.e    = ren_v[i];
          m.done = 1'b0;
          mq.push_back(m);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
